// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: registers, a priority bus mux and an inc/shr/pass ALU feeding Z.
// Latency: loads land one clock after the strobe. Backpressure: none; the sequencer owns every strobe.
module cpu_datapath #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [WIDTH-1:0]   MDatain,
  input  logic [WIDTH-1:0]   in_port,
  input  logic               Read,
  input  logic               PCout,
  input  logic               Zlowout,
  input  logic               Zhighout,
  input  logic               MDRout,
  input  logic               R2out,
  input  logic               R3out,
  input  logic               LOout,
  input  logic               HIout,
  input  logic               InPortout,
  input  logic               Cout,
  input  logic               R1in,
  input  logic               R2in,
  input  logic               R3in,
  input  logic               PCin,
  input  logic               IRin,
  input  logic               MARin,
  input  logic               MDRin,
  input  logic               Yin,
  input  logic               Zin,
  input  logic               HIin,
  input  logic               LOin,
  input  logic               IncPC,
  input  logic               SHR,
  output logic [WIDTH-1:0]   bus_q,
  output logic [WIDTH-1:0]   R1_q,
  output logic [WIDTH-1:0]   R2_q,
  output logic [WIDTH-1:0]   R3_q,
  output logic [WIDTH-1:0]   PC_q,
  output logic [WIDTH-1:0]   IR_q,
  output logic [WIDTH-1:0]   MAR_q,
  output logic [WIDTH-1:0]   MDR_q,
  output logic [WIDTH-1:0]   Y_q,
  output logic [WIDTH-1:0]   Zlow_q,
  output logic [WIDTH-1:0]   Zhigh_q
);

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] z_q;
  logic [2*WIDTH-1:0] alu_res;
  logic [WIDTH-1:0]   c_sext;

  assign Zlow_q  = z_q[WIDTH-1:0];
  assign Zhigh_q = z_q[2*WIDTH-1:WIDTH];
  assign c_sext  = {{(WIDTH-19){IR_q[18]}}, IR_q[18:0]};

  // Multiple strobes is a sequencer bug; the fixed priority keeps it deterministic.
  always_comb begin
    bus_q = '0;
    if (MDRout)         bus_q = MDR_q;
    else if (PCout)     bus_q = PC_q;
    else if (Zlowout)   bus_q = Zlow_q;
    else if (Zhighout)  bus_q = Zhigh_q;
    else if (R2out)     bus_q = R2_q;
    else if (R3out)     bus_q = R3_q;
    else if (HIout)     bus_q = hi_q;
    else if (LOout)     bus_q = lo_q;
    else if (InPortout) bus_q = in_port;
    else if (Cout)      bus_q = c_sext;
  end

  always_comb begin
    alu_res = '0;
    if (IncPC)    alu_res[WIDTH-1:0] = bus_q + WIDTH'(1);
    else if (SHR) alu_res[WIDTH-1:0] = Y_q >> bus_q[SHAMT_BITS-1:0];
    else          alu_res[WIDTH-1:0] = bus_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      R1_q  <= '0;
      R2_q  <= '0;
      R3_q  <= '0;
      PC_q  <= '0;
      IR_q  <= '0;
      MAR_q <= '0;
      MDR_q <= '0;
      Y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= '0;
    end else begin
      if (R1in)  R1_q  <= bus_q;
      if (R2in)  R2_q  <= bus_q;
      if (R3in)  R3_q  <= bus_q;
      if (PCin)  PC_q  <= bus_q;
      if (IRin)  IR_q  <= bus_q;
      if (MARin) MAR_q <= bus_q;
      if (Yin)   Y_q   <= bus_q;
      if (HIin)  hi_q  <= bus_q;
      if (LOin)  lo_q  <= bus_q;
      if (MDRin) MDR_q <= Read ? MDatain : bus_q;
      if (Zin)   z_q   <= alu_res;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;

  logic        clk;
  logic        clr;
  logic [31:0] MDatain, in_port;
  logic        Read;
  logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out, LOout, HIout, InPortout, Cout;
  logic        R1in, R2in, R3in, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic        IncPC, SHR;
  logic [31:0] bus_q, R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q, Zhigh_q;

  int tests_run;
  int tests_failed;

  cpu_datapath #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clk(clk), .clr(clr), .MDatain(MDatain), .in_port(in_port), .Read(Read),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(R2out), .R3out(R3out), .LOout(LOout), .HIout(HIout),
    .InPortout(InPortout), .Cout(Cout),
    .R1in(R1in), .R2in(R2in), .R3in(R3in), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .SHR(SHR),
    .bus_q(bus_q), .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .PC_q(PC_q),
    .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q),
    .Zlow_q(Zlow_q), .Zhigh_q(Zhigh_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Read = 0;
    PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; R2out = 0; R3out = 0;
    LOout = 0; HIout = 0; InPortout = 0; Cout = 0;
    R1in = 0; R2in = 0; R3in = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0;
    Yin = 0; Zin = 0; HIin = 0; LOin = 0; IncPC = 0; SHR = 0;
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle(); MDatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    MDatain = '0;
    in_port = '0;
    idle();
    clr = 0;
    #2;
    chk("rst_R1", R1_q, 32'h0);
    chk("rst_PC", PC_q, 32'h0);
    chk("rst_MDR", MDR_q, 32'h0);
    chk("rst_Zlow", Zlow_q, 32'h0);
    chk("rst_bus", bus_q, 32'h0);
    @(negedge clk);
    clr = 1;
    tick();

    // Register loads through MDR
    load_mdr(32'd3);
    chk("mdr_mem", MDR_q, 32'd3);
    idle(); MDRout = 1; R2in = 1;
    #1 chk("bus_mdr", bus_q, 32'd3);
    chk("r2_before_edge", R2_q, 32'd0);
    tick();
    chk("r2_load", R2_q, 32'd3);
    load_mdr(32'd2);
    idle(); MDRout = 1; R3in = 1; tick();
    chk("r3_load", R3_q, 32'd2);
    load_mdr(32'h18);
    idle(); MDRout = 1; R1in = 1; tick();
    chk("r1_load", R1_q, 32'h18);

    // Fetch
    idle(); PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    chk("t0_mar", MAR_q, 32'h0);
    chk("t0_zlow", Zlow_q, 32'h1);
    idle(); Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; MDatain = 32'h28918000; tick();
    chk("t1_pc", PC_q, 32'h1);
    chk("t1_mdr", MDR_q, 32'h28918000);
    idle(); MDRout = 1; IRin = 1; tick();
    chk("t2_ir", IR_q, 32'h28918000);
    idle(); Cout = 1;
    #1 chk("cout_pos", bus_q, 32'h00018000);
    load_mdr(32'h12344ABC);
    idle(); MDRout = 1; IRin = 1; tick();
    idle(); Cout = 1;
    #1 chk("cout_neg", bus_q, 32'hFFFC4ABC);

    // SHR: 3 >> 2 then 3 >> 0
    idle(); R2out = 1; Yin = 1; tick();
    chk("t3_y", Y_q, 32'd3);
    idle(); R3out = 1; SHR = 1; Zin = 1; tick();
    chk("t4_zlow", Zlow_q, 32'd0);
    idle(); Zlowout = 1; R1in = 1; tick();
    chk("t5_r1", R1_q, 32'd0);
    idle(); R2out = 1; Yin = 1; tick();
    idle(); SHR = 1; Zin = 1; tick();
    idle(); Zlowout = 1; R1in = 1; tick();
    chk("shr0_r1", R1_q, 32'd3);

    // Shift boundaries
    load_mdr(32'h80000000);
    idle(); MDRout = 1; Yin = 1; tick();
    load_mdr(32'd31);
    idle(); MDRout = 1; SHR = 1; Zin = 1; tick();
    chk("shr31_lo", Zlow_q, 32'h1);
    chk("shr31_hi", Zhigh_q, 32'h0);
    load_mdr(32'h21);
    idle(); MDRout = 1; SHR = 1; Zin = 1; tick();
    chk("shr_mask", Zlow_q, 32'h40000000);

    // Wrap, op priority, pass-through
    load_mdr(32'hFFFFFFFF);
    idle(); MDRout = 1; IncPC = 1; Zin = 1; tick();
    chk("wrap_lo", Zlow_q, 32'h0);
    chk("wrap_hi", Zhigh_q, 32'h0);
    idle(); Zhighout = 1;
    #1 chk("bus_zhigh", bus_q, 32'h0);
    load_mdr(32'd5);
    idle(); MDRout = 1; IncPC = 1; SHR = 1; Zin = 1; tick();
    chk("inc_over_shr", Zlow_q, 32'd6);
    idle(); MDRout = 1; Zin = 1; tick();
    chk("pass", Zlow_q, 32'd5);

    // Bus priority
    idle(); MDRout = 1; PCout = 1;
    #1 chk("prio_mdr_pc", bus_q, 32'd5);
    idle(); PCout = 1; Zlowout = 1;
    #1 chk("prio_pc_zlow", bus_q, 32'd1);
    idle(); R2out = 1; R3out = 1;
    #1 chk("prio_r2_r3", bus_q, 32'd3);

    // HI/LO, in_port, self-reload
    in_port = 32'hA5A5_0F0F;
    idle(); InPortout = 1; HIin = 1; tick();
    in_port = 32'h0000_BEEF;
    idle(); InPortout = 1; LOin = 1; tick();
    idle(); HIout = 1; LOout = 1;
    #1 chk("hi_over_lo", bus_q, 32'hA5A5_0F0F);
    idle(); LOout = 1; InPortout = 1;
    #1 chk("lo_over_inport", bus_q, 32'h0000_BEEF);
    idle(); R2out = 1; R2in = 1; tick();
    chk("self_reload", R2_q, 32'd3);

    // Reset mid-operation
    load_mdr(32'h18);
    idle(); MDRout = 1; R1in = 1; tick();
    chk("pre_rst_r1", R1_q, 32'h18);
    in_port = 32'h77;
    idle(); InPortout = 1; R1in = 1;
    #2 clr = 0;
    #1;
    chk("arst_r1", R1_q, 32'h0);
    chk("arst_mdr", MDR_q, 32'h0);
    chk("arst_y", Y_q, 32'h0);
    chk("arst_zlow", Zlow_q, 32'h0);
    chk("arst_ir", IR_q, 32'h0);
    tick();
    chk("load_in_rst", R1_q, 32'h0);
    clr = 1;
    tick();
    chk("load_after_rst", R1_q, 32'h77);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
